sign_narrow: RTL and testbench

Streaming 9-bit to 8-bit two's-complement narrower, the inverse of the divider's 8-to-9-bit sign extension. It takes 9-bit signed divider results (quotient or remainder) over a valid/ready handshake and buffers them in a 2-entry FIFO. It emits 8-bit results with a per-sample overflow flag and keeps a sticky overflow indicator and a saturating overflow event counter for status readout. It sits between the divider datapath and any 8-bit consumer.

---
 rtl/sign_narrow.sv | 128 ++++++++++++
 tb/tb_sign_narrow.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - streaming 9-bit to 8-bit signed narrower with 2-entry FIFO and overflow status
//
// Narrows 9-bit two's-complement divider results to 8 bits. Each accepted word
// is tagged with an overflow flag (bits 8 and 7 differ) and queued in a 2-entry
// FIFO. A sticky overflow flag and a saturating overflow event counter are kept
// for status readout.
//
// Build option: define SIGN_NARROW_SATURATE_EN to clamp overflowing words to
// 0x7F / 0x80 by sign. Without it, overflowing words wrap to in_data[7:0].
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    input word valid
//   in_data     9-bit signed input word
//   in_ready    block accepts a word this cycle (decoded from registers only)
//   out_valid   FIFO head holds a word
//   out_data    narrowed 8-bit word at FIFO head
//   out_ovf     head word did not fit in 8 bits
//   out_ready   consumer takes the head word this cycle
//   ovf_clr     synchronous clear of ovf_sticky and ovf_cnt
//   ovf_sticky  an overflowing word was accepted since last clear/reset
//   ovf_cnt     count of accepted overflowing words, saturating at 255

module sign_narrow (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_ovf,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       ovf_sticky,
    output logic [7:0] ovf_cnt
);

    // FIFO held as an explicit head register plus one spill register; entry
    // layout is {ovf, data[7:0]}.
    logic [1:0] count;
    logic [8:0] head_q;
    logic [8:0] tail_q;

    logic       push;
    logic       pop;
    logic       in_ovf;
    logic [7:0] in_narrow;
    logic [8:0] in_entry;

    assign in_ovf = in_data[8] ^ in_data[7];

    always_comb begin
        in_narrow = in_data[7:0];
`ifdef SIGN_NARROW_SATURATE_EN
        if (in_ovf) begin
            in_narrow = in_data[8] ? 8'h80 : 8'h7F;
        end
`endif
    end

    assign in_entry  = {in_ovf, in_narrow};

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = head_q[7:0];
    assign out_ovf   = head_q[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head_q <= 9'd0;
            tail_q <= 9'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head_q <= in_entry;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    // Push and pop together: the new word replaces the head.
                    if (push && pop) begin
                        head_q <= in_entry;
                    end else if (push) begin
                        tail_q <= in_entry;
                        count  <= 2'd2;
                    end else if (pop) begin
                        count  <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: in_ready is low, so only a pop can happen here.
                    if (pop) begin
                        head_q <= tail_q;
                        count  <= 2'd1;
                    end
                end
                default: begin
                    count <= 2'd0;
                end
            endcase
        end
    end

    // Clear takes priority over the stored state but not over a coincident
    // overflowing push, which is counted after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= 8'd0;
        end else if (ovf_clr) begin
            ovf_sticky <= push && in_ovf;
            ovf_cnt    <= (push && in_ovf) ? 8'd1 : 8'd0;
        end else if (push && in_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// tb/tb_sign_narrow.sv - directed self-checking bench for sign_narrow

module tb_sign_narrow;

`ifdef SIGN_NARROW_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_ready;
    logic       ovf_clr;
    logic       ovf_sticky;
    logic [7:0] ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] vin  [0:15];
    logic [7:0] vexp [0:15];
    logic       vovf [0:15];

    sign_narrow dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_ready  (out_ready),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [8:0] d, input logic [7:0] e, input logic o);
        vin[i]  = d;
        vexp[i] = e;
        vovf[i] = o;
    endtask

    // Back-to-back stream with out_ready high: each word must appear one
    // cycle after its push while the next word is pushed, in_ready staying high.
    task automatic run_stream(input string tag, input int n);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vin[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d].valid", tag, i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("%s[%0d].data", tag, i), {24'd0, out_data}, {24'd0, vexp[i]});
            chk($sformatf("%s[%0d].ovf", tag, i), {31'd0, out_ovf}, {31'd0, vovf[i]});
            chk($sformatf("%s[%0d].ready", tag, i), {31'd0, in_ready}, 32'd1);
            if (i < n - 1) in_data = vin[i + 1];
            else           in_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s.drained", tag), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 9'd0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.in_ready",  {31'd0, in_ready},   32'd1);
        chk("rst.out_valid", {31'd0, out_valid},  32'd0);
        chk("rst.out_data",  {24'd0, out_data},   32'h00);
        chk("rst.out_ovf",   {31'd0, out_ovf},    32'd0);
        chk("rst.sticky",    {31'd0, ovf_sticky}, 32'd0);
        chk("rst.cnt",       {24'd0, ovf_cnt},    32'd0);

        // In-range pass-through
        out_ready = 1'b1;
        set_vec(0, 9'h07F, 8'h7F, 1'b0);
        set_vec(1, 9'h180, 8'h80, 1'b0);
        set_vec(2, 9'h000, 8'h00, 1'b0);
        set_vec(3, 9'h1FF, 8'hFF, 1'b0);
        run_stream("pass", 4);
        chk("pass.sticky", {31'd0, ovf_sticky}, 32'd0);

        // Overflow, both directions
        set_vec(0, 9'h0C8, SAT ? 8'h7F : 8'hC8, 1'b1);
        set_vec(1, 9'h138, SAT ? 8'h80 : 8'h38, 1'b1);
        run_stream("ovf", 2);
        chk("ovf.sticky", {31'd0, ovf_sticky}, 32'd1);
        chk("ovf.cnt",    {24'd0, ovf_cnt},    32'd2);

        // Backpressure: two accepted, third refused until drain
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'h011;
        @(negedge clk);
        chk("bp.head1",   {24'd0, out_data}, 32'h11);
        chk("bp.ready1",  {31'd0, in_ready}, 32'd1);
        in_data = 9'h022;
        @(negedge clk);
        chk("bp.ready2",  {31'd0, in_ready}, 32'd0);
        chk("bp.head2",   {24'd0, out_data}, 32'h11);
        in_data = 9'h033;
        @(negedge clk);
        chk("bp.ready3",  {31'd0, in_ready},  32'd0);
        chk("bp.hold",    {24'd0, out_data},  32'h11);
        chk("bp.valid",   {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.drain1",  {24'd0, out_data}, 32'h22);
        chk("bp.ready4",  {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp.drain2",  {24'd0, out_data}, 32'h33);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.empty",   {31'd0, out_valid}, 32'd0);

        // Ten-word stream at count 1 with simultaneous push/pop
        set_vec(0, 9'h005, 8'h05, 1'b0);
        set_vec(1, 9'h1FE, 8'hFE, 1'b0);
        set_vec(2, 9'h040, 8'h40, 1'b0);
        set_vec(3, 9'h1C0, 8'hC0, 1'b0);
        set_vec(4, 9'h07E, 8'h7E, 1'b0);
        set_vec(5, 9'h181, 8'h81, 1'b0);
        set_vec(6, 9'h010, 8'h10, 1'b0);
        set_vec(7, 9'h1F0, 8'hF0, 1'b0);
        set_vec(8, 9'h033, 8'h33, 1'b0);
        set_vec(9, 9'h1CC, 8'hCC, 1'b0);
        run_stream("strm", 10);
        chk("strm.cnt", {24'd0, ovf_cnt}, 32'd2);

        // Counter saturation
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'h100;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat.cnt",    {24'd0, ovf_cnt},    32'd255);
        chk("sat.sticky", {31'd0, ovf_sticky}, 32'd1);

        // Clear coinciding with an overflowing push
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        ovf_clr  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        chk("clrpush.cnt",    {24'd0, ovf_cnt},    32'd1);
        chk("clrpush.sticky", {31'd0, ovf_sticky}, 32'd1);
        chk("clrpush.ovf",    {31'd0, out_ovf},    32'd1);
        chk("clrpush.data",   {24'd0, out_data},   SAT ? 32'h7F : 32'hFF);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr.cnt",    {24'd0, ovf_cnt},    32'd0);
        chk("clr.sticky", {31'd0, ovf_sticky}, 32'd0);

        // Reset mid-operation with two words buffered and ovf_cnt = 5
        set_vec(0, 9'h100, SAT ? 8'h80 : 8'h00, 1'b1);
        set_vec(1, 9'h17F, SAT ? 8'h80 : 8'h7F, 1'b1);
        set_vec(2, 9'h0AA, SAT ? 8'h7F : 8'hAA, 1'b1);
        run_stream("pre", 3);
        chk("pre.cnt", {24'd0, ovf_cnt}, 32'd3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'h0AB;
        @(negedge clk);
        in_data = 9'h154;
        @(negedge clk);
        chk("pre.full", {31'd0, in_ready}, 32'd0);
        chk("pre.cnt5", {24'd0, ovf_cnt},  32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mrst.out_valid", {31'd0, out_valid},  32'd0);
        chk("mrst.in_ready",  {31'd0, in_ready},   32'd1);
        chk("mrst.cnt",       {24'd0, ovf_cnt},    32'd0);
        chk("mrst.sticky",    {31'd0, ovf_sticky}, 32'd0);
        chk("mrst.out_data",  {24'd0, out_data},   32'h00);
        chk("mrst.out_ovf",   {31'd0, out_ovf},    32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("mrst.nostale",   {31'd0, out_valid},  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
